// File: rtl/fft_find_top_peaks.sv
// Top-N peak finder over one frame of bit-reverse-ordered FFT magnitudes.
// Optional noise-floor estimate enabled by defining FFT_PEAK_NOISE_FLOOR_EN.
module fft_find_top_peaks #(
  parameter int NSamples = 1024,
  parameter int W        = 33,
  parameter int NPeaks   = 4,
  parameter int NBits    = $clog2(NSamples),
  parameter int CBits    = $clog2(NPeaks + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             mag,
  input  logic                     mag_valid,
  input  logic [NBits-1:0]         k_min,
  input  logic [W-1:0]             mag_thresh,
  input  logic                     restart,
  output logic [NPeaks*W-1:0]      peaks,
  output logic [NPeaks*NBits-1:0]  peaks_k,
  output logic [CBits-1:0]         peak_count,
  output logic                     peak_valid
`ifdef FFT_PEAK_NOISE_FLOOR_EN
  ,
  output logic [W-1:0]             noise_floor
`endif
);

  logic [W-1:0]            slot_mag_q [NPeaks];
  logic [W-1:0]            slot_mag_d [NPeaks];
  logic [NBits-1:0]        slot_k_q   [NPeaks];
  logic [NBits-1:0]        slot_k_d   [NPeaks];
  logic [NPeaks-1:0]       slot_full_q, slot_full_d;

  logic [W-1:0]            ins_mag  [NPeaks];
  logic [NBits-1:0]        ins_k    [NPeaks];
  logic [NPeaks-1:0]       ins_full;
  logic [NPeaks-1:0]       take;

  logic [NBits-1:0]        i_q, i_d;
  logic [NBits-1:0]        k_cur;
  logic                    accept, in_band, eligible, last_sample;

  logic [NPeaks*W-1:0]     peaks_q, peaks_d;
  logic [NPeaks*NBits-1:0] peaks_k_q, peaks_k_d;
  logic [CBits-1:0]        peak_count_q, peak_count_d;
  logic [CBits-1:0]        ins_count;
  logic                    peak_valid_q, peak_valid_d;

  // Samples arrive in bit-reversed order, so the bin index is the mirrored counter.
  always_comb begin
    k_cur = '0;
    for (int b = 0; b < NBits; b++) begin
      k_cur[b] = i_q[NBits-1-b];
    end
  end

  always_comb begin
    accept      = mag_valid && !restart;
    in_band     = !k_cur[NBits-1] && (k_cur >= k_min);
    eligible    = accept && in_band && (mag > mag_thresh);
    last_sample = accept && (i_q == NBits'(NSamples - 1));
  end

  // Slots stay sorted, so "take" is monotonic and its first set bit is the insert point.
  always_comb begin
    for (int j = 0; j < NPeaks; j++) begin
      take[j] = !slot_full_q[j] || (slot_mag_q[j] < mag);
    end

    if (eligible && take[0]) begin
      ins_mag[0]  = mag;
      ins_k[0]    = k_cur;
      ins_full[0] = 1'b1;
    end else begin
      ins_mag[0]  = slot_mag_q[0];
      ins_k[0]    = slot_k_q[0];
      ins_full[0] = slot_full_q[0];
    end

    for (int j = 1; j < NPeaks; j++) begin
      if (eligible && take[j]) begin
        if (take[j-1]) begin
          ins_mag[j]  = slot_mag_q[j-1];
          ins_k[j]    = slot_k_q[j-1];
          ins_full[j] = slot_full_q[j-1];
        end else begin
          ins_mag[j]  = mag;
          ins_k[j]    = k_cur;
          ins_full[j] = 1'b1;
        end
      end else begin
        ins_mag[j]  = slot_mag_q[j];
        ins_k[j]    = slot_k_q[j];
        ins_full[j] = slot_full_q[j];
      end
    end

    ins_count = '0;
    for (int j = 0; j < NPeaks; j++) begin
      ins_count = ins_count + CBits'(ins_full[j]);
    end
  end

  always_comb begin
    slot_mag_d   = slot_mag_q;
    slot_k_d     = slot_k_q;
    slot_full_d  = slot_full_q;
    i_d          = i_q;
    peaks_d      = peaks_q;
    peaks_k_d    = peaks_k_q;
    peak_count_d = peak_count_q;
    peak_valid_d = 1'b0;

    if (restart) begin
      for (int j = 0; j < NPeaks; j++) begin
        slot_mag_d[j] = '0;
        slot_k_d[j]   = '0;
      end
      slot_full_d = '0;
      i_d         = '0;
    end else if (accept) begin
      if (last_sample) begin
        // Final sample goes straight to the outputs; working slots restart empty.
        for (int j = 0; j < NPeaks; j++) begin
          peaks_d[j*W +: W]         = ins_mag[j];
          peaks_k_d[j*NBits +: NBits] = ins_k[j];
          slot_mag_d[j]             = '0;
          slot_k_d[j]               = '0;
        end
        peak_count_d = ins_count;
        peak_valid_d = 1'b1;
        slot_full_d  = '0;
        i_d          = '0;
      end else begin
        slot_mag_d  = ins_mag;
        slot_k_d    = ins_k;
        slot_full_d = ins_full;
        i_d         = i_q + NBits'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NPeaks; j++) begin
        slot_mag_q[j] <= '0;
        slot_k_q[j]   <= '0;
      end
      slot_full_q  <= '0;
      i_q          <= '0;
      peaks_q      <= '0;
      peaks_k_q    <= '0;
      peak_count_q <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      slot_mag_q   <= slot_mag_d;
      slot_k_q     <= slot_k_d;
      slot_full_q  <= slot_full_d;
      i_q          <= i_d;
      peaks_q      <= peaks_d;
      peaks_k_q    <= peaks_k_d;
      peak_count_q <= peak_count_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign peaks      = peaks_q;
  assign peaks_k    = peaks_k_q;
  assign peak_count = peak_count_q;
  assign peak_valid = peak_valid_q;

`ifdef FFT_PEAK_NOISE_FLOOR_EN
  localparam int AccBits = W + NBits - 1;

  logic [AccBits-1:0] acc_q, acc_d, acc_sum;
  logic [W-1:0]       noise_floor_q, noise_floor_d;

  // Dividing by NSamples/2 is a plain shift; the threshold does not gate the mean.
  always_comb begin
    acc_sum       = acc_q + ((accept && in_band) ? AccBits'(mag) : '0);
    acc_d         = acc_q;
    noise_floor_d = noise_floor_q;
    if (restart) begin
      acc_d = '0;
    end else if (accept) begin
      if (last_sample) begin
        noise_floor_d = acc_sum[AccBits-1 -: W];
        acc_d         = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q         <= '0;
      noise_floor_q <= '0;
    end else begin
      acc_q         <= acc_d;
      noise_floor_q <= noise_floor_d;
    end
  end

  assign noise_floor = noise_floor_q;
`endif

endmodule

// File: tb/tb_fft_find_top_peaks.sv
// Bench for fft_find_top_peaks: directed table, restart/reset sequences, random frames
// checked against a sort-based reference model (noise floor when FFT_PEAK_NOISE_FLOOR_EN).
module tb_fft_find_top_peaks;
  localparam int NSamples = 1024;
  localparam int W        = 33;
  localparam int NPeaks   = 4;
  localparam int NBits    = $clog2(NSamples);
  localparam int CBits    = $clog2(NPeaks + 1);

  logic                    clk, reset;
  logic [W-1:0]            mag;
  logic                    mag_valid;
  logic [NBits-1:0]        k_min;
  logic [W-1:0]            mag_thresh;
  logic                    restart;
  logic [NPeaks*W-1:0]     peaks;
  logic [NPeaks*NBits-1:0] peaks_k;
  logic [CBits-1:0]        peak_count;
  logic                    peak_valid;
`ifdef FFT_PEAK_NOISE_FLOOR_EN
  logic [W-1:0]            noise_floor;
`endif

  fft_find_top_peaks #(.NSamples(NSamples), .W(W), .NPeaks(NPeaks)) dut (
    .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid), .k_min(k_min),
    .mag_thresh(mag_thresh), .restart(restart), .peaks(peaks), .peaks_k(peaks_k),
    .peak_count(peak_count), .peak_valid(peak_valid)
`ifdef FFT_PEAK_NOISE_FLOOR_EN
    , .noise_floor(noise_floor)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sk[3];
    int sm[3];
    int kmin;
    int thr;
    bit gaps;
    int em[4];
    int ek[4];
    int ec;
  } vec_t;

  vec_t tbl[8];
  int   n_vec, n_err, spurious;

  logic [W-1:0]            frame_mag [NSamples];
  logic [W-1:0]            m_mag [NPeaks];
  logic [NBits-1:0]        m_k   [NPeaks];
  int                      m_cnt;
  logic [W-1:0]            m_nf;
  logic [NPeaks*W-1:0]     held_peaks, exp_p;
  logic [NPeaks*NBits-1:0] held_k, exp_k;
  logic [CBits-1:0]        held_cnt;

  function automatic vec_t mk(int k0, int m0, int k1, int m1, int k2, int m2, int kmin, int thr,
                              bit gaps, int e0, int e1, int e2, int e3,
                              int x0, int x1, int x2, int x3, int ec);
    vec_t v;
    v.sk[0] = k0; v.sk[1] = k1; v.sk[2] = k2;
    v.sm[0] = m0; v.sm[1] = m1; v.sm[2] = m2;
    v.kmin = kmin; v.thr = thr; v.gaps = gaps;
    v.em[0] = e0; v.em[1] = e1; v.em[2] = e2; v.em[3] = e3;
    v.ek[0] = x0; v.ek[1] = x1; v.ek[2] = x2; v.ek[3] = x3;
    v.ec = ec;
    return v;
  endfunction

  function automatic int rev_bits(int x);
    int r = 0;
    for (int b = 0; b < NBits; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: collect eligible samples in arrival order, then stable top-N by magnitude.
  task automatic compute_model(input int kmin, input logic [W-1:0] thr);
    logic [W-1:0] q_mag[$];
    int           q_k[$];
    bit           used[$];
    logic [63:0]  sum;
    int           best;
    sum = 0;
    for (int i = 0; i < NSamples; i++) begin
      int k = rev_bits(i);
      if (k < NSamples / 2 && k >= kmin) begin
        sum = sum + 64'(frame_mag[k]);
        if (frame_mag[k] > thr) begin
          q_mag.push_back(frame_mag[k]);
          q_k.push_back(k);
          used.push_back(1'b0);
        end
      end
    end
    m_nf  = W'(sum / (NSamples / 2));
    m_cnt = 0;
    for (int s = 0; s < NPeaks; s++) begin
      best = -1;
      for (int e = 0; e < q_mag.size(); e++) begin
        if (!used[e] && (best < 0 || q_mag[e] > q_mag[best])) best = e;
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        m_mag[s] = q_mag[best];
        m_k[s]   = NBits'(q_k[best]);
        m_cnt++;
      end else begin
        m_mag[s] = '0;
        m_k[s]   = '0;
      end
    end
  endtask

  task automatic pack_model();
    for (int s = 0; s < NPeaks; s++) begin
      exp_p[s*W +: W]         = m_mag[s];
      exp_k[s*NBits +: NBits] = m_k[s];
    end
  endtask

  task automatic load_row(input int r);
    for (int k = 0; k < NSamples; k++) frame_mag[k] = '0;
    for (int s = 0; s < 3; s++) begin
      if (tbl[r].sm[s] != 0) frame_mag[tbl[r].sk[s]] = W'(tbl[r].sm[s]);
    end
    k_min      = NBits'(tbl[r].kmin);
    mag_thresh = W'(tbl[r].thr);
  endtask

  task automatic drive_sample(input logic [W-1:0] m);
    @(negedge clk);
    if (peak_valid) spurious++;
    mag       = m;
    mag_valid = 1'b1;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    if (peak_valid) spurious++;
    mag       = {1'b1, 32'($urandom)};
    mag_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit gaps);
    spurious = 0;
    for (int i = 0; i < NSamples; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) drive_idle();
      drive_sample(frame_mag[rev_bits(i)]);
    end
    @(negedge clk);
    mag_valid = 1'b0;
    mag       = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [CBits-1:0] ec);
    cmp({tag, "_strobe"}, 160'(peak_valid), 160'(1));
    cmp({tag, "_early_strobe"}, 160'(spurious), 160'(0));
    cmp({tag, "_peaks"}, 160'(peaks), 160'(exp_p));
    cmp({tag, "_peaks_k"}, 160'(peaks_k), 160'(exp_k));
    cmp({tag, "_count"}, 160'(peak_count), 160'(ec));
`ifdef FFT_PEAK_NOISE_FLOOR_EN
    cmp({tag, "_noise"}, 160'(noise_floor), 160'(m_nf));
`endif
    held_peaks = exp_p;
    held_k     = exp_k;
    held_cnt   = ec;
    @(negedge clk);
    cmp({tag, "_strobe_width"}, 160'(peak_valid), 160'(0));
  endtask

  task automatic run_row(input int r);
    load_row(r);
    compute_model(tbl[r].kmin, W'(tbl[r].thr));
    for (int s = 0; s < NPeaks; s++) begin
      exp_p[s*W +: W]         = W'(tbl[r].em[s]);
      exp_k[s*NBits +: NBits] = NBits'(tbl[r].ek[s]);
    end
    applyStimulus(tbl[r].gaps);
    checkOutput($sformatf("row%0d", r), CBits'(tbl[r].ec));
  endtask

  initial begin
    n_vec = 0; n_err = 0; spurious = 0;
    mag = '0; mag_valid = 1'b0; k_min = '0; mag_thresh = '0; restart = 1'b0;

    tbl[0] = mk(5, 100, 9, 300, 3, 200, 1, 0, 0, 300, 200, 100, 0, 9, 3, 5, 0, 3);
    tbl[1] = mk(0, 999, 600, 999, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // k=20 mirrors to i=160 and k=10 to i=320, so k=20 is accepted first and wins the tie.
    tbl[2] = mk(10, 50, 20, 50, 0, 0, 1, 0, 0, 50, 50, 0, 0, 20, 10, 0, 0, 2);
    tbl[3] = mk(5, 100, 9, 300, 3, 200, 1, 200, 0, 300, 0, 0, 0, 9, 0, 0, 0, 1);
    tbl[4] = mk(5, 400, 511, 300, 512, 600, 5, 0, 0, 400, 300, 0, 0, 5, 511, 0, 0, 2);
    tbl[5] = mk(4, 500, 6, 7, 1023, 900, 5, 0, 0, 7, 0, 0, 0, 6, 0, 0, 0, 1);
    tbl[6] = mk(5, 100, 9, 300, 3, 200, 1, 0, 1, 300, 200, 100, 0, 9, 3, 5, 0, 3);
    tbl[7] = mk(5, 100, 9, 300, 3, 200, 1, 100, 0, 300, 200, 0, 0, 9, 3, 0, 0, 2);

    reset = 1'b1;
    #2;
    cmp("reset_peaks", 160'(peaks), 160'(0));
    cmp("reset_peaks_k", 160'(peaks_k), 160'(0));
    cmp("reset_count", 160'(peak_count), 160'(0));
    cmp("reset_valid", 160'(peak_valid), 160'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 8; r++) run_row(r);

    // Abort at i=500 after a 900 peak at i=100; the same-cycle sample is dropped.
    for (int k = 0; k < NSamples; k++) frame_mag[k] = '0;
    frame_mag[rev_bits(100)] = 900;
    k_min = 1; mag_thresh = 0;
    spurious = 0;
    for (int i = 0; i < 500; i++) drive_sample(frame_mag[rev_bits(i)]);
    @(negedge clk);
    if (peak_valid) spurious++;
    restart = 1'b1; mag_valid = 1'b1; mag = 5000;
    @(negedge clk);
    if (peak_valid) spurious++;
    restart = 1'b0; mag_valid = 1'b0;
    @(negedge clk);
    cmp("restart_no_strobe", 160'(spurious + int'(peak_valid)), 160'(0));
    cmp("restart_held_peaks", 160'(peaks), 160'(held_peaks));
    cmp("restart_held_k", 160'(peaks_k), 160'(held_k));
    cmp("restart_held_count", 160'(peak_count), 160'(held_cnt));
    run_row(0);

    // Async reset mid-frame: outputs clear at once, partial frame is discarded.
    load_row(0);
    for (int i = 0; i < 300; i++) drive_sample(frame_mag[rev_bits(i)]);
    @(negedge clk);
    mag_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    cmp("midreset_peaks", 160'(peaks), 160'(0));
    cmp("midreset_peaks_k", 160'(peaks_k), 160'(0));
    cmp("midreset_count", 160'(peak_count), 160'(0));
    cmp("midreset_valid", 160'(peak_valid), 160'(0));
`ifdef FFT_PEAK_NOISE_FLOOR_EN
    cmp("midreset_noise", 160'(noise_floor), 160'(0));
`endif
    @(negedge clk);
    reset = 1'b0;
    run_row(0);

`ifdef FFT_PEAK_NOISE_FLOOR_EN
    for (int k = 0; k < NSamples; k++) frame_mag[k] = 8;
    k_min = 0; mag_thresh = 1000;
    compute_model(0, 1000);
    pack_model();
    applyStimulus(1'b0);
    cmp("noise_flat8", 160'(noise_floor), 160'(8));
    checkOutput("noise_frame", CBits'(m_cnt));
`endif

    // Random frames with many ties, wide magnitudes and random DC-skip/threshold.
    for (int r = 0; r < 6; r++) begin
      int kmin_r;
      logic [W-1:0] thr_r;
      for (int k = 0; k < NSamples; k++) begin
        frame_mag[k] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : '0;
      end
      for (int n = 0; n < 3; n++) frame_mag[$urandom_range(0, NSamples - 1)] = {1'b1, 32'($urandom)};
      kmin_r = $urandom_range(0, 600);
      thr_r  = W'($urandom_range(0, 8));
      k_min = NBits'(kmin_r); mag_thresh = thr_r;
      compute_model(kmin_r, thr_r);
      pack_model();
      applyStimulus(bit'(r % 2));
      checkOutput($sformatf("rand%0d", r), CBits'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
